// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared types, segment table and sizing helpers for the
//             multi-digit seven-segment scan driver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } conv_state_t;

    // Active-high segment pattern for '-' (segment g only).
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Active-high segments {g,f,e,d,c,b,a}; lowercase b and d.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Largest value representable on the given number of decimal digits.
    function automatic longint unsigned max_dec(input int digits);
        longint unsigned v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    // BCD bits needed to hold any unsigned value of data_w bits.
    function automatic int bcd_width(input int data_w);
        longint unsigned maxv;
        int              n;
        maxv = (64'd1 << data_w) - 64'd1;
        n    = 0;
        while (maxv != 64'd0) begin
            n    = n + 1;
            maxv = maxv / 64'd10;
        end
        if (n == 0) begin
            n = 1;
        end
        return 4 * n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_display_if.sv
// ============================================================================
//  Module   : seg7_scan_display_if
//  Brief    : Value/mode inputs and display pin outputs of the scan driver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16
);
    logic [DATA_W-1:0]     Number;
    logic                  Mode;
    logic                  LeadBlank;
    logic [6:0]            out7;
    logic [NUM_DIGITS-1:0] en_out;
    logic                  Busy;

    modport master (
        output Number, Mode, LeadBlank,
        input  out7, en_out, Busy
    );

    modport slave (
        input  Number, Mode, LeadBlank,
        output out7, en_out, Busy
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// ============================================================================
//  Module   : bin2bcd_seq
//  Brief    : Iterative double-dabble converter, one bit per cycle,
//             DATA_W cycles from start to final BCD.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BCD_W  = bcd_width(DATA_W)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_start,
    input  wire logic [DATA_W-1:0] i_bin,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [BCD_W-1:0]       o_bcd
);

    localparam int c_cnt_w = $clog2(DATA_W + 1);

    logic [BCD_W-1:0]   r_bcd;
    logic [DATA_W-1:0]  r_bin;
    logic [c_cnt_w-1:0] r_cnt;
    logic [BCD_W-1:0]   w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bcd <= '0;
            r_bin <= i_bin;
            r_cnt <= c_cnt_w'(DATA_W);
        end else if (r_cnt != '0) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
            r_bin <= {r_bin[DATA_W-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // o_done marks the cycle whose edge performs the final step.
    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == c_cnt_w'(1));
    assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_display.sv
// ============================================================================
//  Module   : seg7_scan_display
//  Brief    : Multi-digit seven-segment scan driver with hex/decimal modes,
//             leading-zero blanking and overflow dashes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  wire logic          Clock,
    input  wire logic          Reset,
    seg7_scan_display_if.slave bus
);

    localparam int              c_bcd_w   = bcd_width(DATA_W);
    localparam int              c_dig_w   = 4 * NUM_DIGITS;
    localparam int              c_pad_w   = (c_bcd_w > c_dig_w) ? c_bcd_w : c_dig_w;
    localparam int              c_hpad_w  = (DATA_W > c_dig_w) ? DATA_W : c_dig_w;
    localparam longint unsigned c_max_dec = max_dec(NUM_DIGITS);
    localparam int              c_presc_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int              c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]      c_pol7    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] c_polen = (ACTIVE_LOW != 0) ? '1 : '0;

    conv_state_t                 r_state;
    logic [DATA_W-1:0]           r_sh_num;
    logic                        r_sh_mode;
    logic                        r_sh_ovf;
    logic                        r_busy;
    logic [NUM_DIGITS-1:0][3:0]  r_disp_digits;
    logic                        r_disp_ovf;
    logic [c_presc_w-1:0]        r_presc;
    logic [c_idx_w-1:0]          r_idx;
    logic [6:0]                  r_out7;
    logic [NUM_DIGITS-1:0]       r_en;

    logic                        w_dec_ovf;
    logic                        w_hex_ovf;
    logic                        w_ovf;
    logic                        w_start;
    logic                        w_cvt_busy;
    logic                        w_done;
    logic [c_bcd_w-1:0]          w_bcd;
    logic [c_pad_w-1:0]          w_bcd_pad;
    logic [c_hpad_w-1:0]         w_hex_pad;
    logic [c_dig_w-1:0]          w_bcd_digits;
    logic [c_dig_w-1:0]          w_hex_digits;
    logic [NUM_DIGITS-1:0]       w_upper_zero;
    logic                        w_acc;
    logic                        w_blank;
    logic [3:0]                  w_cur;
    logic [6:0]                  w_seg;
    logic [NUM_DIGITS-1:0]       w_en;

    // ------------------------------------------------------------------
    // Overflow detection on the live input, captured alongside it
    // ------------------------------------------------------------------
    assign w_dec_ovf = (64'(bus.Number) > c_max_dec);

    generate
        if (c_dig_w < DATA_W) begin : g_hex_ovf
            assign w_hex_ovf = |bus.Number[DATA_W-1:c_dig_w];
        end else begin : g_hex_fit
            assign w_hex_ovf = 1'b0;
        end
    endgenerate

    assign w_ovf   = bus.Mode ? w_dec_ovf : w_hex_ovf;
    assign w_start = (r_state == ST_IDLE) && bus.Mode && !w_dec_ovf;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .BCD_W  (c_bcd_w)
    ) u_bin2bcd (
        .clk     (Clock),
        .rst     (Reset),
        .i_start (w_start),
        .i_bin   (bus.Number),
        .o_busy  (w_cvt_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    assign w_bcd_pad    = c_pad_w'(w_bcd);
    assign w_bcd_digits = w_bcd_pad[c_dig_w-1:0];
    assign w_hex_pad    = c_hpad_w'(r_sh_num);
    assign w_hex_digits = w_hex_pad[c_dig_w-1:0];

    // ------------------------------------------------------------------
    // Converter control: capture, iterate, latch atomically
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_sh_num      <= '0;
            r_sh_mode     <= 1'b0;
            r_sh_ovf      <= 1'b0;
            r_busy        <= 1'b0;
            r_disp_digits <= '0;
            r_disp_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sh_num  <= bus.Number;
                    r_sh_mode <= bus.Mode;
                    r_sh_ovf  <= w_ovf;
                    if (bus.Mode && !w_dec_ovf) begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_LATCH;
                    end
                end
                ST_SHIFT: begin
                    if (w_done) begin
                        r_state <= ST_LATCH;
                        r_busy  <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    r_disp_digits <= r_sh_mode ? w_bcd_digits : w_hex_digits;
                    r_disp_ovf    <= r_sh_ovf;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan: digit content and leading-zero blanking
    // ------------------------------------------------------------------
    always_comb begin
        w_upper_zero = '0;
        w_acc        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc           = w_acc & (r_disp_digits[i] == 4'd0);
            w_upper_zero[i] = w_acc;
        end
    end

    assign w_cur   = r_disp_digits[r_idx];
    assign w_blank = bus.LeadBlank && !r_disp_ovf && (r_idx != '0) && w_upper_zero[r_idx];
    assign w_seg   = r_disp_ovf ? SEG_DASH : hex_to_seg(w_cur);
    assign w_en    = w_blank ? '0 : (NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_out7  <= c_pol7;
            r_en    <= c_polen;
        end else begin
            if (r_presc == c_presc_w'(REFRESH_DIV - 1)) begin
                r_presc <= '0;
                if (r_idx == c_idx_w'(NUM_DIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_out7 <= w_seg ^ c_pol7;
            r_en   <= w_en ^ c_polen;
        end
    end

    assign bus.out7   = r_out7;
    assign bus.en_out = r_en;
    assign bus.Busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
// ============================================================================
//  Module   : tb_seg7_scan_display
//  Brief    : Self-checking bench for seg7_scan_display with a cycle-level
//             behavioural model and directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_display;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg7_scan_display_if #(.NUM_DIGITS(N), .DATA_W(W)) bus ();

    seg7_scan_display #(
        .NUM_DIGITS  (N),
        .DATA_W      (W),
        .REFRESH_DIV (RD),
        .ACTIVE_LOW  (1)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what the pins must show, derived from values
    // ------------------------------------------------------------------
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int              m_presc, m_idx, m_cnt, m_len;
    int              m_disp [N];
    int              m_pdig [N];
    bit              m_ovf, m_conv, m_pmode, m_povf, m_live, m_allz;
    longint unsigned m_n, m_p;
    logic [6:0]      m_seg;
    logic [6:0]      e_out7;
    logic [N-1:0]    e_en;
    logic            e_busy;
    bit              e_chk7;

    always @(posedge clk) begin
        m_live = 1'b1;
        if (rst) begin
            m_presc = 0;
            m_idx   = 0;
            m_ovf   = 1'b0;
            m_conv  = 1'b0;
            m_cnt   = 0;
            for (int j = 0; j < N; j++) m_disp[j] = 0;
            e_out7 = 7'h7F;
            e_en   = '1;
            e_busy = 1'b0;
            e_chk7 = 1'b1;
        end else begin
            m_allz = 1'b1;
            for (int j = m_idx; j < N; j++) if (m_disp[j] != 0) m_allz = 1'b0;
            m_seg  = m_ovf ? 7'h40 : seg_tab[m_disp[m_idx]];
            e_out7 = ~m_seg;
            if (bus.LeadBlank && !m_ovf && m_idx != 0 && m_allz) begin
                e_en   = '1;
                e_chk7 = 1'b0;
            end else begin
                e_en   = ~(N'(1) << m_idx);
                e_chk7 = 1'b1;
            end

            m_presc++;
            if (m_presc == RD) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % N;
            end

            if (!m_conv) begin
                m_n     = 64'(bus.Number);
                m_pmode = bus.Mode;
                m_p     = 64'd1;
                if (bus.Mode) begin
                    m_povf = (m_n > 64'd9999);
                    for (int j = 0; j < N; j++) begin
                        m_pdig[j] = int'((m_n / m_p) % 64'd10);
                        m_p       = m_p * 64'd10;
                    end
                end else begin
                    m_povf = (m_n >= (64'd1 << (4 * N)));
                    for (int j = 0; j < N; j++) m_pdig[j] = int'((m_n >> (4 * j)) & 64'hF);
                end
                m_len  = (!bus.Mode || m_povf) ? 1 : W + 1;
                m_cnt  = 0;
                m_conv = 1'b1;
            end else begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    for (int j = 0; j < N; j++) m_disp[j] = m_pdig[j];
                    m_ovf  = m_povf;
                    m_conv = 1'b0;
                end
            end
            e_busy = m_conv && m_pmode && !m_povf && (m_cnt < W);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_en_out", 32'(bus.en_out), 32'(e_en));
            check("cmp_busy", 32'(bus.Busy), 32'(e_busy));
            if (e_chk7) check("cmp_out7", 32'(bus.out7), 32'(e_out7));
        end
    end

    bit busy_seen;
    always @(negedge clk) if (bus.Busy === 1'b1) busy_seen = 1'b1;

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic check_digit(input int idx, input logic [6:0] exp7, input string name);
        logic [N-1:0] want;
        bit           hit;
        want = ~(N'(1) << idx);
        hit  = 1'b0;
        for (int k = 0; k < 64 && !hit; k++) begin
            @(negedge clk);
            if (bus.en_out === want) hit = 1'b1;
        end
        if (hit) begin
            check(name, 32'(bus.out7), 32'(exp7));
        end else begin
            checks++;
            failures++;
            $display("FAIL %s timeout en_out=%b required=%b", name, bus.en_out, want);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 80 && !hit; k++) begin
            @(negedge clk);
            if (bus.Busy === lvl) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s timeout Busy=%b required=%b", name, bus.Busy, lvl);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    int  len;
    bit  upper_on;

    initial begin
        bus.Number    = '0;
        bus.Mode      = 1'b0;
        bus.LeadBlank = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out7", 32'(bus.out7), 32'h7F);
        check("reset_en_out", 32'(bus.en_out), 32'hF);
        check("reset_busy", 32'(bus.Busy), 32'h0);

        rst = 1'b0;
        @(negedge clk);
        check("first_en_out", 32'(bus.en_out), 32'b1110);
        check("first_out7", 32'(bus.out7), 32'h40);
        repeat (4) @(negedge clk);
        check("scan_advance", 32'(bus.en_out), 32'b1101);
        repeat (12) @(negedge clk);
        check("scan_wrap", 32'(bus.en_out), 32'b1110);

        // hex
        bus.Number = 16'hBEEF;
        busy_seen  = 1'b0;
        repeat (3) @(negedge clk);
        check_digit(0, 7'h0E, "hex_d0_F");
        check_digit(2, 7'h06, "hex_d2_E");
        check_digit(3, 7'h03, "hex_d3_b");
        check("hex_no_busy", 32'(busy_seen), 32'h0);

        // decimal
        bus.Number = 16'd1234;
        bus.Mode   = 1'b1;
        wait_busy(1'b1, "dec_busy_rise");
        len = 0;
        while (bus.Busy === 1'b1 && len < 40) begin
            len++;
            @(negedge clk);
        end
        check("dec_busy_len", 32'(len), 32'd16);
        check_digit(0, 7'h19, "dec_d0_4");
        check_digit(1, 7'h30, "dec_d1_3");
        check_digit(2, 7'h24, "dec_d2_2");
        check_digit(3, 7'h79, "dec_d3_1");

        // decimal overflow
        bus.Number    = 16'd10000;
        bus.LeadBlank = 1'b1;
        repeat (25) @(negedge clk);
        busy_seen = 1'b0;
        repeat (20) @(negedge clk);
        check("ovf_no_busy", 32'(busy_seen), 32'h0);
        for (int d = 0; d < N; d++) check_digit(d, 7'h3F, "ovf_dash");

        // leading blank
        bus.Number = 16'd7;
        repeat (25) @(negedge clk);
        upper_on = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (bus.en_out[3:1] !== 3'b111) upper_on = 1'b1;
        end
        check("blank_upper_off", 32'(upper_on), 32'h0);
        check_digit(0, 7'h78, "blank_d0_7");
        bus.Number = 16'd0;
        repeat (25) @(negedge clk);
        check_digit(0, 7'h40, "blank_d0_0");

        // reset mid-conversion
        bus.Number = 16'd9999;
        wait_busy(1'b0, "abort_busy_low");
        wait_busy(1'b1, "abort_busy_high");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.Busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_disp_zero", 32'(bus.out7), 32'h40);
        check("abort_en_out", 32'(bus.en_out), 32'b1110);
        repeat (25) @(negedge clk);
        check_digit(3, 7'h10, "fresh_d3_9");

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 3))
                0: bus.Number = 16'($urandom_range(0, 20));
                1: bus.Number = 16'($urandom_range(0, 9999));
                2: bus.Number = 16'($urandom_range(9990, 10010));
                default: bus.Number = 16'($urandom);
            endcase
            bus.Mode      = 1'($urandom_range(0, 1));
            bus.LeadBlank = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
